// File: rtl/spi_rr_scheduler.sv
// -----------------------------------------------------------------------------
// spi_rr_scheduler
// Shares one SPI mode-0 bus (CPOL=0, CPHA=0) between NUM_REQ requesters. Each
// requester asks for one full-duplex DATA_W-bit transfer to its own slave. The
// block arbitrates round-robin, generates SCLK, drives one chip select, shifts
// MOSI out MSB first and captures MISO.
//
// Ports
//   clk_i      system clock, all logic on posedge
//   reset_i    asynchronous, active-high reset
//   req_i      level request, one bit per requester
//   wr_data_i  requester i transmit word in bits [i*DATA_W +: DATA_W]
//   grant_o    one-hot 1-clk pulse: word latched, requester is being served
//   done_o     one-hot 1-clk pulse: transfer finished, rd_data_o valid
//   rd_data_o  last received MISO word, held until the next done
//   busy_o     high whenever the scheduler is not idle
//   spi_clk_o  SCLK, idle low
//   cs_n_o     active-low chip selects, at most one low
//   mosi_o     serial data out
//   miso_i     serial data in
// -----------------------------------------------------------------------------
module spi_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HALF_PERIOD = 2,
  parameter int CS_GAP      = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      busy_o,
  output logic                      spi_clk_o,
  output logic [NUM_REQ-1:0]        cs_n_o,
  output logic                      mosi_o,
  input  logic                      miso_i
);

  localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                last_q, last_d;      // final falling SCLK edge already issued
  logic [PTR_W-1:0]    ptr_q, ptr_d;        // RR pointer; equals the served requester
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic                spi_clk_q, spi_clk_d;
  logic                mosi_q, mosi_d;

  logic                hp_last, gap_last, any_req;
  logic [PTR_W-1:0]    arb_idx, cand;
  logic [NUM_REQ-1:0]  arb_oh, sel_oh;
  logic [DATA_W-1:0]   tx_slice, tx_shift;

  assign hp_last  = (hp_cnt_q == HP_W'(HALF_PERIOD - 1));
  assign gap_last = (gap_cnt_q == GAP_W'(CS_GAP - 1));
  assign arb_oh   = NUM_REQ'(1) << arb_idx;
  assign sel_oh   = NUM_REQ'(1) << ptr_q;
  assign tx_shift = tx_q << 1;

  // Round-robin search: first set request strictly after the pointer, wrapping.
  // NOTE: every signal written in an always_comb gets a default at the top so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    any_req = 1'b0;
    arb_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    tx_slice = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == PTR_W'(i)) tx_slice = wr_data_i[i*DATA_W +: DATA_W];
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_SETUP;
      S_SETUP: if (hp_last) state_d = S_SHIFT;
      // Leave SHIFT at the end of the low half-period that follows the last fall.
      S_SHIFT: if (hp_last && !spi_clk_q && last_q) state_d = S_HOLD;
      S_HOLD:  if (hp_last) state_d = S_GAP;
      S_GAP:   if (hp_last && gap_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: next values of the registered outputs and shifters.
  always_comb begin
    hp_cnt_d  = hp_last ? '0 : hp_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    last_d    = last_q;
    ptr_d     = ptr_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    grant_d   = '0;
    done_d    = '0;
    cs_n_d    = cs_n_q;
    spi_clk_d = spi_clk_q;
    mosi_d    = mosi_q;
    unique case (state_q)
      S_IDLE: begin
        hp_cnt_d  = '0;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        last_d    = 1'b0;
        if (any_req) begin
          grant_d   = arb_oh;
          ptr_d     = arb_idx;
          tx_d      = tx_slice;
          mosi_d    = tx_slice[DATA_W-1];
          cs_n_d    = ~arb_oh;
          spi_clk_d = 1'b0;
        end
      end
      S_SETUP: begin
        // First rising SCLK edge: sample MISO as the clock goes high.
        if (hp_last) begin
          spi_clk_d = 1'b1;
          rx_d      = (rx_q << 1) | DATA_W'(miso_i);
        end
      end
      S_SHIFT: begin
        if (hp_last) begin
          if (spi_clk_q) begin
            spi_clk_d = 1'b0;
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              last_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_d      = tx_shift;
              mosi_d    = tx_shift[DATA_W-1];
            end
          end else if (!last_q) begin
            spi_clk_d = 1'b1;
            rx_d      = (rx_q << 1) | DATA_W'(miso_i);
          end
        end
      end
      S_HOLD: begin
        if (hp_last) begin
          cs_n_d    = '1;
          done_d    = sel_oh;
          rd_data_d = rx_q;
          mosi_d    = 1'b0;
        end
      end
      S_GAP: begin
        if (hp_last) gap_cnt_d = gap_last ? '0 : gap_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hp_cnt_q  <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      last_q    <= 1'b0;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      cs_n_q    <= '1;
      spi_clk_q <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      hp_cnt_q  <= hp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      ptr_q     <= ptr_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      spi_clk_q <= spi_clk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign grant_o   = grant_q;
  assign done_o    = done_q;
  assign rd_data_o = rd_data_q;
  assign busy_o    = (state_q != S_IDLE);
  assign spi_clk_o = spi_clk_q;
  assign cs_n_o    = cs_n_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_rr_scheduler
// Scoreboard bench for spi_rr_scheduler. Stimulus pushes the predicted
// transfers (winner, transmitted word, received word) into a queue; monitors
// pop them on grant/done and also watch the SPI pins. A second instance runs
// with HALF_PERIOD=1 in loopback.
// -----------------------------------------------------------------------------
module tb_spi_rr_scheduler;
  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int HP   = 2;
  localparam int GAP  = 2;
  localparam int LAT  = (2*DW+2)*HP;
  localparam int LAT1 = (2*DW+2);

  typedef struct {
    int         idx;
    logic [7:0] tx;
    logic [7:0] rd;
  } xfer_t;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]    req, grant, done, cs_n;
  logic [NR*DW-1:0] wr_data;
  logic [DW-1:0]    rd_data;
  logic busy, spi_clk, mosi, miso, miso_slave;
  int   miso_mode;  // 0 loopback, 1 tied 0, 2 tied 1, 3 slave model

  logic [NR-1:0]    req2, grant2, done2, cs_n2;
  logic [NR*DW-1:0] wr_data2;
  logic [DW-1:0]    rd_data2;
  logic busy2, spi_clk2, mosi2;

  logic [7:0] slave_byte [NR];
  xfer_t exp_q[$], fly_q[$], exp2_q[$], fly2_q[$];
  int total = 0, bad = 0;
  int model_ptr;

  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? 1'b0 :
                (miso_mode == 2) ? 1'b1 : miso_slave;

  spi_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .HALF_PERIOD(HP), .CS_GAP(GAP)) u_dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .wr_data_i(wr_data),
    .grant_o(grant), .done_o(done), .rd_data_o(rd_data), .busy_o(busy),
    .spi_clk_o(spi_clk), .cs_n_o(cs_n), .mosi_o(mosi), .miso_i(miso)
  );

  spi_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .HALF_PERIOD(1), .CS_GAP(GAP)) u_dut_hp1 (
    .clk_i(clk), .reset_i(reset), .req_i(req2), .wr_data_i(wr_data2),
    .grant_o(grant2), .done_o(done2), .rd_data_o(rd_data2), .busy_o(busy2),
    .spi_clk_o(spi_clk2), .cs_n_o(cs_n2), .mosi_o(mosi2), .miso_i(mosi2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [NR-1:0] pat, input int ptr);
    for (int i = 1; i <= NR; i++) begin
      if (((pat >> ((ptr + i) % NR)) & NR'(1)) != '0) return (ptr + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [7:0] slice_of(input logic [NR*DW-1:0] bus, input int i);
    return 8'(bus >> (i*DW));
  endfunction

  function automatic logic [7:0] exp_rd(input int mode, input int idx, input logic [7:0] tx);
    case (mode)
      0:       return tx;
      1:       return 8'h00;
      2:       return 8'hFF;
      default: return slave_byte[idx];
    endcase
  endfunction

  task automatic set_slice(input int i, input logic [7:0] v);
    logic [NR*DW-1:0] mask;
    mask    = (NR*DW)'(8'hFF) << (i*DW);
    wr_data = (wr_data & ~mask) | ((NR*DW)'(v) << (i*DW));
  endtask

  task automatic push_phase(input logic [NR-1:0] pat, input int k);
    xfer_t x;
    for (int j = 0; j < k; j++) begin
      model_ptr = rr_pick(pat, model_ptr);
      x.idx = model_ptr;
      x.tx  = slice_of(wr_data, model_ptr);
      x.rd  = exp_rd(miso_mode, model_ptr, x.tx);
      exp_q.push_back(x);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input string name);
    int budget;
    budget = LAT + 60;
    while (grant == '0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, 32'(grant != '0), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 6*(LAT + 20);
    while ((exp_q.size() != 0 || fly_q.size() != 0 || busy) && budget > 0) begin
      tick();
      budget--;
    end
    check(name, 32'(exp_q.size() + fly_q.size()) + 32'(busy), 32'd0);
  endtask

  task automatic run_phase(input logic [NR-1:0] pat, input int k, input string name);
    int got, budget;
    push_phase(pat, k);
    req    = pat;
    got    = 0;
    budget = k*(LAT + 20) + 60;
    while (got < k && budget > 0) begin
      tick();
      if (grant != '0) got++;
      budget--;
    end
    req = '0;
    check({name, "_grants"}, got, k);
    wait_drain({name, "_drain"});
  endtask

  // ---------------- monitor: main instance ----------------
  int   cyc = 0, grant_cyc, sclk_rises, slave_falls, gap_cnt, cs_idx, cs_viol = 0;
  logic prev_sclk, cs_active, seen_xfer;
  logic [7:0] cap_word;

  always @(negedge clk) begin
    xfer_t x;
    logic [7:0] sb;
    cyc++;
    if (reset) begin
      prev_sclk = 1'b0; cs_active = 1'b0; seen_xfer = 1'b0;
      gap_cnt = 0; sclk_rises = 0; slave_falls = 0; miso_slave = 1'b0;
    end else begin
      if (grant != '0) begin
        if (exp_q.size() == 0) check("unexpected_grant", 32'(grant), 32'd0);
        else begin
          x = exp_q.pop_front();
          check("grant_vec", 32'(grant), 32'(NR'(1) << x.idx));
          fly_q.push_back(x);
          grant_cyc = cyc;
        end
      end
      if (done != '0) begin
        if (fly_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          x = fly_q.pop_front();
          check("done_vec", 32'(done), 32'(NR'(1) << x.idx));
          check("rd_data", 32'(rd_data), 32'(x.rd));
          check("latency", cyc - grant_cyc, LAT);
          check("mosi_word", 32'(cap_word), 32'(x.tx));
          check("sclk_pulses", sclk_rises, DW);
        end
      end
      if ($countones(~cs_n) > 1) cs_viol++;
      if (cs_n == '1) begin
        cs_active = 1'b0;
        gap_cnt++;
        if (spi_clk) cs_viol++;
      end else begin
        if (!busy) cs_viol++;
        if (fly_q.size() != 0 && cs_n != ~(NR'(1) << fly_q[0].idx)) cs_viol++;
        if (!cs_active) begin
          cs_active = 1'b1; cap_word = '0; sclk_rises = 0; slave_falls = 0;
          for (int i = 0; i < NR; i++) if (!cs_n[i]) cs_idx = i;
          if (seen_xfer) begin
            total++;
            if (gap_cnt < GAP*HP) begin
              bad++;
              $display("FAIL cs_gap: got %0d clks need >= %0d", gap_cnt, GAP*HP);
            end
          end
          seen_xfer = 1'b1;
        end
        gap_cnt = 0;
      end
      if (spi_clk && !prev_sclk) begin
        cap_word = {cap_word[6:0], mosi};
        sclk_rises++;
      end
      if (!spi_clk && prev_sclk) slave_falls++;
      prev_sclk = spi_clk;
      // Mode-0 slave: presents its MSB at select, next bit after each fall.
      if (cs_active) begin
        sb = slave_byte[cs_idx];
        sb = sb << slave_falls;
        miso_slave = sb[7];
      end else miso_slave = 1'b0;
    end
  end

  // ---------------- monitor: HALF_PERIOD=1 instance ----------------
  int   grant2_cyc, rises2, first_rise2, last_rise2;
  logic prev_sclk2 = 1'b0;

  always @(negedge clk) begin
    xfer_t x;
    if (!reset) begin
      if (grant2 != '0) begin
        if (exp2_q.size() == 0) check("hp1_unexpected_grant", 32'(grant2), 32'd0);
        else begin
          x = exp2_q.pop_front();
          check("hp1_grant_vec", 32'(grant2), 32'(NR'(1) << x.idx));
          fly2_q.push_back(x);
          grant2_cyc = cyc;
          rises2 = 0;
        end
      end
      if (spi_clk2 && !prev_sclk2) begin
        if (rises2 == 0) first_rise2 = cyc;
        last_rise2 = cyc;
        rises2++;
      end
      prev_sclk2 = spi_clk2;
      if (done2 != '0) begin
        if (fly2_q.size() == 0) check("hp1_unexpected_done", 32'(done2), 32'd0);
        else begin
          x = fly2_q.pop_front();
          check("hp1_done_vec", 32'(done2), 32'(NR'(1) << x.idx));
          check("hp1_latency", cyc - grant2_cyc, LAT1);
          check("hp1_rd_data", 32'(rd_data2), 32'(x.rd));
          check("hp1_sclk_pulses", rises2, DW);
          check("hp1_sclk_span", last_rise2 - first_rise2, 2*(DW-1));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int rises, budget, idx;
    logic prev;
    logic [7:0] b;
    xfer_t x;

    reset = 1'b1; req = '0; wr_data = '0; miso_mode = 0;
    req2 = '0; wr_data2 = '0; model_ptr = NR-1;
    for (int i = 0; i < NR; i++) slave_byte[i] = 8'h00;
    repeat (3) tick();
    check("rst_grant",   32'(grant),   32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_cs_n",    32'(cs_n),    32'hF);
    check("rst_mosi",    32'(mosi),    32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // All four requesting with distinct words: order 0,1,2,3,0 after reset.
    wr_data = 32'h44_33_22_11;
    run_phase(4'b1111, 5, "rr_all");

    // Loopback 0xA5 on requester 0.
    set_slice(0, 8'hA5);
    run_phase(4'b0001, 1, "loop_a5");

    // MISO tied high with 0x00 out; MISO tied low with 0xFF out.
    miso_mode = 2; set_slice(1, 8'h00);
    run_phase(4'b0010, 1, "miso_one");
    miso_mode = 1; set_slice(2, 8'hFF);
    run_phase(4'b0100, 1, "miso_zero");

    // Drop req and corrupt the word right after grant: original word still sent.
    miso_mode = 0; set_slice(1, 8'h3C);
    push_phase(4'b0010, 1);
    req = 4'b0010;
    wait_grant("drop_grant");
    req = '0; set_slice(1, 8'h00);
    wait_drain("drop_drain");

    // Randomised patterns, loopback or slave-driven MISO.
    for (int r = 0; r < 6; r++) begin
      miso_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
      for (int i = 0; i < NR; i++) slave_byte[i] = 8'($urandom);
      wr_data = (NR*DW)'($urandom);
      run_phase(NR'($urandom_range(1, 15)), $urandom_range(1, 4), "rand");
    end

    // Reset mid-transfer after the 4th rising SCLK edge of a req[2] transfer.
    miso_mode = 0; set_slice(2, 8'h5A);
    push_phase(4'b0100, 1);
    req = 4'b0100;
    wait_grant("mid_rst_grant");
    req = '0;
    rises = 0; prev = spi_clk; budget = LAT + 10;
    while (rises < 4 && budget > 0) begin
      tick();
      if (spi_clk && !prev) rises++;
      prev = spi_clk;
      budget--;
    end
    check("mid_rst_4th_rise", rises, 4);
    #1 reset = 1'b1;
    exp_q.delete(); fly_q.delete(); model_ptr = NR-1;
    #1;
    check("mid_rst_cs_n",    32'(cs_n),    32'hF);
    check("mid_rst_spi_clk", 32'(spi_clk), 32'd0);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_done",    32'(done),    32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    wr_data = 32'h0D_0C_0B_0A;
    run_phase(4'b0101, 2, "post_rst");

    // HALF_PERIOD=1 instance, loopback.
    for (int r = 0; r < 3; r++) begin
      b   = 8'($urandom);
      idx = $urandom_range(0, NR-1);
      wr_data2 = (NR*DW)'(b) << (idx*DW);
      x.idx = idx; x.tx = b; x.rd = b;
      exp2_q.push_back(x);
      req2 = NR'(1) << idx;
      budget = 40;
      while (grant2 == '0 && budget > 0) begin tick(); budget--; end
      req2 = '0;
      check("hp1_grant_seen", 32'(grant2 != '0), 32'd1);
      budget = 60;
      while ((exp2_q.size() != 0 || fly2_q.size() != 0 || busy2) && budget > 0) begin
        tick(); budget--;
      end
      check("hp1_drain", 32'(exp2_q.size() + fly2_q.size()) + 32'(busy2), 32'd0);
    end

    check("cs_violations", cs_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
